// File: rtl/reg_id_pkg.sv
// Architectural x86-64 register identifiers and the value-plus-flags register record.
// Real registers occupy 8'h80..8'h93; low ids are constant or special pseudo-registers.
package reg_id_pkg;

  typedef logic [7:0] reg_id_t;

  typedef struct packed {
    logic        cf;
    logic        zf;
    logic        sf;
    logic        of;
    logic        pf;
    logic        af;
    logic [63:0] val;
  } reg_val_t;

  localparam reg_id_t rnil     = 8'h00;
  localparam reg_id_t rv0      = 8'h01;
  localparam reg_id_t rv8      = 8'h02;
  localparam reg_id_t rip      = 8'h10;
  localparam reg_id_t rimm     = 8'h11;
  localparam reg_id_t rsyscall = 8'h12;

  localparam reg_id_t rax = 8'h80;
  localparam reg_id_t rcx = 8'h81;
  localparam reg_id_t rdx = 8'h82;
  localparam reg_id_t rbx = 8'h83;
  localparam reg_id_t rsp = 8'h84;
  localparam reg_id_t rbp = 8'h85;
  localparam reg_id_t rsi = 8'h86;
  localparam reg_id_t rdi = 8'h87;
  localparam reg_id_t r8  = 8'h88;
  localparam reg_id_t r9  = 8'h89;
  localparam reg_id_t r10 = 8'h8A;
  localparam reg_id_t r11 = 8'h8B;
  localparam reg_id_t r12 = 8'h8C;
  localparam reg_id_t r13 = 8'h8D;
  localparam reg_id_t r14 = 8'h8E;
  localparam reg_id_t r15 = 8'h8F;
  localparam reg_id_t rhx = 8'h90;
  localparam reg_id_t rha = 8'h91;
  localparam reg_id_t rhb = 8'h92;
  localparam reg_id_t rhc = 8'h93;

  localparam reg_id_t REG_ID_BASE   = rax;
  localparam int      NUM_ARCH_REGS = 20;

  function automatic logic reg_is_const(input reg_id_t id);
    return (id == rnil) || (id == rv0) || (id == rv8);
  endfunction

  function automatic logic reg_is_arch(input reg_id_t id);
    return (id >= rax) && (id <= rhc);
  endfunction

endpackage

// File: rtl/regfile_pkg.sv
// Defaults, tag type and read-side helpers shared by the scoreboarded register file.
package regfile_pkg;
  import reg_id_pkg::*;

  localparam int REG_FILE_SIZE_DEF = NUM_ARCH_REGS;
  localparam int NUM_RD_DEF        = 4;
  localparam int NUM_WB_DEF        = 2;
  localparam int TAG_W_DEF         = 3;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  function automatic reg_val_t reg_const_val(input reg_id_t id);
    reg_val_t v;
    v = '0;
    if (id == rv8) v.val = 64'd8;
    return v;
  endfunction

  function automatic logic reg_readable(input reg_id_t id);
    return reg_is_const(id) || reg_is_arch(id);
  endfunction

endpackage

// File: rtl/reg_sb_entry.sv
// One architectural register: stored record plus its pending-write count and youngest tag.
// Only a writeback carrying the youngest tag updates the value, so out-of-order returns are WAW-safe.
module reg_sb_entry
  import reg_id_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rsv_hit,
  input  logic [NUM_WB-1:0] wb_hit,
  input  logic [TAG_W-1:0]  wb_tag [NUM_WB],
  input  reg_val_t          wb_val [NUM_WB],
  output reg_val_t          val,
  output logic [TAG_W-1:0]  last_tag,
  output logic              full,
  output logic              busy_after_wb,
  output logic              bypass_hit,
  output reg_val_t          bypass_val
);

  localparam int CW = TAG_W + $clog2(NUM_WB + 1) + 1;

  logic [TAG_W-1:0] cnt;
  logic [TAG_W-1:0] cnt_next;
  logic [TAG_W-1:0] eff_tag;
  logic [CW-1:0]    hit_cnt;
  logic [CW-1:0]    cnt_sum;
  logic             underflow;
  logic             dup_match;

  assign full    = &cnt;
  assign eff_tag = rsv_hit ? last_tag + TAG_W'(1) : last_tag;

  // Later ports override earlier ones when two of them match the same tag.
  always_comb begin
    hit_cnt    = '0;
    bypass_hit = 1'b0;
    bypass_val = '0;
    dup_match  = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      hit_cnt = hit_cnt + CW'(wb_hit[p]);
      if (wb_hit[p] && (wb_tag[p] == eff_tag)) begin
        dup_match  = dup_match | bypass_hit;
        bypass_hit = 1'b1;
        bypass_val = wb_val[p];
      end
    end
    cnt_sum       = CW'(cnt) + CW'(rsv_hit);
    underflow     = cnt_sum < hit_cnt;
    cnt_next      = underflow ? '0 : TAG_W'(cnt_sum - hit_cnt);
    busy_after_wb = CW'(cnt) > hit_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val      <= '0;
      cnt      <= '0;
      last_tag <= '0;
    end else begin
      cnt <= cnt_next;
      if (rsv_hit)    last_tag <= eff_tag;
      if (bypass_hit) val      <= bypass_val;
    end
  end

  a_no_dup_wb : assert property (@(posedge clk) disable iff (!reset_n) !dup_match)
    else $error("reg_sb_entry: two writeback ports matched the same tag");

  a_no_idle_wb : assert property (@(posedge clk) disable iff (!reset_n) !underflow)
    else $error("reg_sb_entry: writeback to a register with no pending reservation");

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, multi-writeback register file with per-register pending-write scoreboard.
// Reads are combinational with same-cycle writeback bypass; constant pseudo-registers resolve here.
module reg_file_sb
  import reg_id_pkg::*;
  import regfile_pkg::*;
#(
  parameter int REG_FILE_SIZE = REG_FILE_SIZE_DEF,
  parameter int NUM_RD        = NUM_RD_DEF,
  parameter int NUM_WB        = NUM_WB_DEF,
  parameter int TAG_W         = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  reg_id_t           rd_id   [NUM_RD],
  output reg_val_t          rd_val  [NUM_RD],
  output logic [NUM_RD-1:0] rd_busy,
  output logic [NUM_RD-1:0] rd_err,
  input  logic              rsv_valid,
  input  reg_id_t           rsv_id,
  output logic              rsv_ready,
  output logic [TAG_W-1:0]  rsv_tag,
  input  logic [NUM_WB-1:0] wb_valid,
  input  reg_id_t           wb_id   [NUM_WB],
  input  logic [TAG_W-1:0]  wb_tag  [NUM_WB],
  input  reg_val_t          wb_val  [NUM_WB]
);

  reg_val_t         ent_val      [REG_FILE_SIZE];
  reg_val_t         ent_byp_val  [REG_FILE_SIZE];
  logic [TAG_W-1:0] ent_last_tag [REG_FILE_SIZE];
  logic             ent_full     [REG_FILE_SIZE];
  logic             ent_busy     [REG_FILE_SIZE];
  logic             ent_byp_hit  [REG_FILE_SIZE];
  logic             rsv_fire;

  // Fake ids always accept with tag 0 and touch no entry; reset forces the idle answer.
  always_comb begin
    rsv_ready = 1'b1;
    rsv_tag   = '0;
    if (reset_n) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        if (rsv_id == REG_ID_BASE + 8'(i)) begin
          rsv_ready = !ent_full[i];
          rsv_tag   = ent_last_tag[i] + TAG_W'(1);
        end
      end
    end
  end

  assign rsv_fire = rsv_valid && rsv_ready;

  for (genvar i = 0; i < REG_FILE_SIZE; i++) begin : g_ent
    logic              rsv_hit;
    logic [NUM_WB-1:0] wb_hit;

    assign rsv_hit = rsv_fire && (rsv_id == REG_ID_BASE + 8'(i));

    always_comb begin
      for (int p = 0; p < NUM_WB; p++) begin
        wb_hit[p] = wb_valid[p] && (wb_id[p] == REG_ID_BASE + 8'(i));
      end
    end

    reg_sb_entry #(
      .NUM_WB (NUM_WB),
      .TAG_W  (TAG_W)
    ) u_entry (
      .clk           (clk),
      .reset_n       (reset_n),
      .rsv_hit       (rsv_hit),
      .wb_hit        (wb_hit),
      .wb_tag        (wb_tag),
      .wb_val        (wb_val),
      .val           (ent_val[i]),
      .last_tag      (ent_last_tag[i]),
      .full          (ent_full[i]),
      .busy_after_wb (ent_busy[i]),
      .bypass_hit    (ent_byp_hit[i]),
      .bypass_val    (ent_byp_val[i])
    );
  end

  // Arch ids beyond REG_FILE_SIZE have no backing entry and report as unreadable.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_val[r]  = reg_const_val(rd_id[r]);
      rd_busy[r] = 1'b0;
      rd_err[r]  = !reg_readable(rd_id[r]) || rd_id[r][7];
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        if (rd_id[r] == REG_ID_BASE + 8'(i)) begin
          rd_val[r]  = (reset_n && ent_byp_hit[i]) ? ent_byp_val[i] : ent_val[i];
          rd_busy[r] = reset_n && ent_busy[i];
          rd_err[r]  = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: reset, bypass, WAW ordering, tag wrap,
// same-cycle reserve/writeback and mid-run reset.
module tb_reg_file_sb;
  import reg_id_pkg::*;
  import regfile_pkg::*;

  localparam int NRD = 4;
  localparam int NWB = 2;
  localparam int TW  = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  reg_id_t        rd_id   [NRD];
  reg_val_t       rd_val  [NRD];
  logic [NRD-1:0] rd_busy;
  logic [NRD-1:0] rd_err;
  logic           rsv_valid;
  reg_id_t        rsv_id;
  logic           rsv_ready;
  logic [TW-1:0]  rsv_tag;
  logic [NWB-1:0] wb_valid;
  reg_id_t        wb_id   [NWB];
  logic [TW-1:0]  wb_tag  [NWB];
  reg_val_t       wb_val  [NWB];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_sb #(
    .REG_FILE_SIZE (20),
    .NUM_RD        (NRD),
    .NUM_WB        (NWB),
    .TAG_W         (TW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_id     (rd_id),
    .rd_val    (rd_val),
    .rd_busy   (rd_busy),
    .rd_err    (rd_err),
    .rsv_valid (rsv_valid),
    .rsv_id    (rsv_id),
    .rsv_ready (rsv_ready),
    .rsv_tag   (rsv_tag),
    .wb_valid  (wb_valid),
    .wb_id     (wb_id),
    .wb_tag    (wb_tag),
    .wb_val    (wb_val)
  );

  function automatic reg_val_t mk(input logic [63:0] v);
    reg_val_t t;
    t     = '0;
    t.val = v;
    return t;
  endfunction

  task automatic clear_inputs();
    rsv_valid = 1'b0;
    rsv_id    = rnil;
    wb_valid  = '0;
    for (int p = 0; p < NWB; p++) begin
      wb_id[p]  = rnil;
      wb_tag[p] = '0;
      wb_val[p] = '0;
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic apply_wb(input int p, input reg_id_t id, input logic [TW-1:0] tag, input reg_val_t v);
    wb_valid[p] = 1'b1;
    wb_id[p]    = id;
    wb_tag[p]   = tag;
    wb_val[p]   = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    rd_id[0] = rax; rd_id[1] = rv8; rd_id[2] = rip; rd_id[3] = rnil;
    rsv_valid = 1'b1;
    rsv_id    = rax;
    apply_wb(0, rax, 3'd1, mk(64'hFFFF));
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL reset_rax_val: got %h want %h", rd_val[0], mk(64'd0)); end
    n_cmp++; if (rd_val[1] !== mk(64'd8)) begin n_fail++; $display("[TB] FAIL reset_rv8_val: got %h want %h", rd_val[1], mk(64'd8)); end
    n_cmp++; if (rd_val[2] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL reset_rip_val: got %h want %h", rd_val[2], mk(64'd0)); end
    n_cmp++; if (rd_err !== 4'b0100) begin n_fail++; $display("[TB] FAIL reset_err: got %b want %b", rd_err, 4'b0100); end
    n_cmp++; if (rd_busy !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want %b", rd_busy, 4'b0000); end
    n_cmp++; if (rsv_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rsv_ready: got %b want 1", rsv_ready); end
    n_cmp++; if (rsv_tag !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_rsv_tag: got %0d want 0", rsv_tag); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_inputs();
    rsv_id = rax;
    #1;
    n_cmp++; if (rsv_tag !== 3'd1) begin n_fail++; $display("[TB] FAIL post_reset_rsv_tag: got %0d want 1", rsv_tag); end
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL post_reset_rax_val: got %h want %h", rd_val[0], mk(64'd0)); end
  endtask

  task automatic test_const_ids();
    rd_id[0] = rv0; rd_id[1] = rimm; rd_id[2] = 8'hA0; rd_id[3] = rsyscall;
    #1;
    n_cmp++; if (rd_err !== 4'b1110) begin n_fail++; $display("[TB] FAIL const_err: got %b want %b", rd_err, 4'b1110); end
    n_cmp++; if (rd_busy !== 4'b0000) begin n_fail++; $display("[TB] FAIL const_busy: got %b want %b", rd_busy, 4'b0000); end
    n_cmp++; if (rd_val[2] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL unmapped_val: got %h want %h", rd_val[2], mk(64'd0)); end
    next_cycle();
  endtask

  task automatic test_bypass();
    reg_val_t v;
    v    = mk(64'hDEAD);
    v.zf = 1'b1;
    rd_id[0]  = rcx;
    rsv_valid = 1'b1;
    rsv_id    = rcx;
    #1;
    n_cmp++; if (rsv_tag !== 3'd1) begin n_fail++; $display("[TB] FAIL rcx_rsv_tag: got %0d want 1", rsv_tag); end
    next_cycle();
    apply_wb(0, rcx, 3'd1, v);
    #1;
    n_cmp++; if (rd_val[0] !== v) begin n_fail++; $display("[TB] FAIL rcx_bypass_val: got %h want %h", rd_val[0], v); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rcx_bypass_busy: got %b want 0", rd_busy[0]); end
    next_cycle();
    #1;
    n_cmp++; if (rd_val[0] !== v) begin n_fail++; $display("[TB] FAIL rcx_stored_val: got %h want %h", rd_val[0], v); end
  endtask

  task automatic test_waw();
    rd_id[0] = rdx;
    for (int k = 1; k <= 2; k++) begin
      rsv_valid = 1'b1;
      rsv_id    = rdx;
      #1;
      n_cmp++; if (rsv_tag !== 3'(k)) begin n_fail++; $display("[TB] FAIL rdx_rsv_tag: got %0d want %0d", rsv_tag, k); end
      next_cycle();
    end
    apply_wb(1, rdx, 3'd2, mk(64'd5));
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd5)) begin n_fail++; $display("[TB] FAIL rdx_young_bypass: got %h want %h", rd_val[0], mk(64'd5)); end
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL rdx_busy_after_first: got %b want 1", rd_busy[0]); end
    next_cycle();
    apply_wb(0, rdx, 3'd1, mk(64'd9));
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd5)) begin n_fail++; $display("[TB] FAIL rdx_old_no_bypass: got %h want %h", rd_val[0], mk(64'd5)); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rdx_busy_after_second: got %b want 0", rd_busy[0]); end
    next_cycle();
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd5)) begin n_fail++; $display("[TB] FAIL rdx_final_val: got %h want %h", rd_val[0], mk(64'd5)); end
  endtask

  task automatic test_full_wrap();
    rd_id[0] = r8;
    for (int k = 1; k <= 7; k++) begin
      rsv_valid = 1'b1;
      rsv_id    = r8;
      #1;
      n_cmp++; if (rsv_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL r8_ready_%0d: got %b want 1", k, rsv_ready); end
      n_cmp++; if (rsv_tag !== 3'(k)) begin n_fail++; $display("[TB] FAIL r8_tag_%0d: got %0d want %0d", k, rsv_tag, k); end
      next_cycle();
    end
    rsv_valid = 1'b1;
    rsv_id    = r8;
    #1;
    n_cmp++; if (rsv_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL r8_full_ready: got %b want 0", rsv_ready); end
    next_cycle();
    rsv_id = r8;
    #1;
    n_cmp++; if (rsv_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL r8_still_full: got %b want 0", rsv_ready); end
    apply_wb(0, r8, 3'd7, mk(64'h77));
    next_cycle();
    rsv_valid = 1'b1;
    rsv_id    = r8;
    #1;
    n_cmp++; if (rsv_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL r8_ready_after_wb: got %b want 1", rsv_ready); end
    n_cmp++; if (rsv_tag !== 3'd0) begin n_fail++; $display("[TB] FAIL r8_wrap_tag: got %0d want 0", rsv_tag); end
    n_cmp++; if (rd_val[0] !== mk(64'h77)) begin n_fail++; $display("[TB] FAIL r8_val: got %h want %h", rd_val[0], mk(64'h77)); end
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL r8_busy: got %b want 1", rd_busy[0]); end
    next_cycle();
  endtask

  task automatic test_same_cycle();
    rd_id[0]  = rbx;
    rsv_valid = 1'b1;
    rsv_id    = rbx;
    next_cycle();
    rsv_valid = 1'b1;
    rsv_id    = rbx;
    apply_wb(0, rbx, 3'd1, mk(64'd7));
    #1;
    n_cmp++; if (rsv_tag !== 3'd2) begin n_fail++; $display("[TB] FAIL rbx_second_tag: got %0d want 2", rsv_tag); end
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL rbx_no_bypass: got %h want %h", rd_val[0], mk(64'd0)); end
    next_cycle();
    rsv_id = rbx;
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL rbx_not_updated: got %h want %h", rd_val[0], mk(64'd0)); end
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL rbx_busy: got %b want 1", rd_busy[0]); end
    n_cmp++; if (rsv_tag !== 3'd3) begin n_fail++; $display("[TB] FAIL rbx_next_tag: got %0d want 3", rsv_tag); end
    apply_wb(1, rbx, 3'd2, mk(64'h22));
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'h22)) begin n_fail++; $display("[TB] FAIL rbx_young_bypass: got %h want %h", rd_val[0], mk(64'h22)); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rbx_cnt_unchanged: got %b want 0", rd_busy[0]); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    rd_id[0]  = rsi;
    rsv_valid = 1'b1;
    rsv_id    = rsi;
    next_cycle();
    apply_wb(0, rsi, 3'd1, mk(64'h1234));
    next_cycle();
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'h1234)) begin n_fail++; $display("[TB] FAIL rsi_pre_val: got %h want %h", rd_val[0], mk(64'h1234)); end
    for (int k = 0; k < 3; k++) begin
      rsv_valid = 1'b1;
      rsv_id    = rsi;
      next_cycle();
    end
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL rsi_pending_busy: got %b want 1", rd_busy[0]); end
    reset_n = 1'b0;
    rsv_id  = rsi;
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL rsi_reset_val: got %h want %h", rd_val[0], mk(64'd0)); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rsi_reset_busy: got %b want 0", rd_busy[0]); end
    n_cmp++; if (rsv_tag !== 3'd0) begin n_fail++; $display("[TB] FAIL rsi_reset_tag: got %0d want 0", rsv_tag); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_inputs();
    rsv_valid = 1'b1;
    rsv_id    = rsi;
    #1;
    n_cmp++; if (rsv_tag !== 3'd1) begin n_fail++; $display("[TB] FAIL rsi_tag_restart: got %0d want 1", rsv_tag); end
    next_cycle();
    apply_wb(0, rsi, 3'd3, mk(64'hBAD));
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL rsi_stale_bypass: got %h want %h", rd_val[0], mk(64'd0)); end
    next_cycle();
    #1;
    n_cmp++; if (rd_val[0] !== mk(64'd0)) begin n_fail++; $display("[TB] FAIL rsi_stale_dropped: got %h want %h", rd_val[0], mk(64'd0)); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rsi_final_busy: got %b want 0", rd_busy[0]); end
  endtask

  initial begin
    test_reset();
    test_const_ids();
    test_bypass();
    test_waw();
    test_full_wrap();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
